// File: rtl/accel_sponge_ctrl.sv
// accel_sponge_ctrl: sequences one sponge job between the dual-port local RAM
// and an external keccak core. It absorbs msg_blocks rate blocks, squeezes
// out_len_byte digest bytes back to RAM, and reports errors (bad input, timeout, abort).
// Optional feature: define ACCEL_PERF_CNT_EN to add the perf_cycles busy-cycle counter.
module accel_sponge_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RATE_BITS  = 1344,
  parameter int MAX_BLOCKS = 16,
  parameter int TIMEOUT    = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [7:0]              msg_blocks,
  input  logic [7:0]              out_len_byte,
  input  logic [ADDR_WIDTH-1:0]   in_base_addr,
  input  logic [ADDR_WIDTH-1:0]   out_base_addr,
  output logic                    busy,
  output logic                    done,
  output logic [2:0]              err_code,
  output logic                    mem_en_a,
  output logic                    mem_we_a,
  output logic [ADDR_WIDTH-1:0]   mem_addr_a,
  output logic [DATA_WIDTH-1:0]   mem_wdata_a,
  output logic [DATA_WIDTH/8-1:0] mem_be_a,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_a,
  output logic                    mem_en_b,
  output logic                    mem_we_b,
  output logic [ADDR_WIDTH-1:0]   mem_addr_b,
  output logic [DATA_WIDTH-1:0]   mem_wdata_b,
  output logic [DATA_WIDTH/8-1:0] mem_be_b,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_b,
  output logic                    k_start,
  output logic [63:0]             k_din,
  output logic                    k_din_valid,
  output logic                    k_last_block,
  input  logic                    k_buffer_full,
  input  logic                    k_ready,
  input  logic [63:0]             k_dout,
  input  logic                    k_dout_valid
`ifdef ACCEL_PERF_CNT_EN
  ,
  output logic [31:0]             perf_cycles
`endif
);

  localparam int RATE_LANES = RATE_BITS / 64;
  localparam int RATE_BYTES = RATE_BITS / 8;
  localparam int LANE_W     = $clog2(RATE_LANES);
  localparam int WAIT_W     = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, CHECK, INIT, ABSORB, WAIT_PERM, SQUEEZE, DONE, ERROR
  } state_t;

  state_t                  state, state_next;
  logic [2:0]              err_next;
  logic [7:0]              blocks_q;
  logic [7:0]              blk_cnt;
  logic [LANE_W-1:0]       lane_cnt;
  logic [7:0]              rem_bytes;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [WAIT_W-1:0]       wait_cnt;
  logic                    rd_issue;
  logic                    wr_fire;
  logic                    wait_count_en;
  logic                    last_blk;
  logic                    tail_lane;

  assign busy      = (state != IDLE) && (state != DONE) && (state != ERROR);
  assign last_blk  = (blk_cnt == blocks_q - 8'd1);
  assign tail_lane = (rem_bytes < 8'd8);
  assign k_din     = k_din_valid ? {mem_rdata_b, mem_rdata_a} : '0;

  // Next-state, error code and core handshake; abort outranks timeout, timeout outranks normal flow
  always_comb begin
    state_next    = state;
    err_next      = err_code;
    k_start       = 1'b0;
    k_last_block  = 1'b0;
    rd_issue      = 1'b0;
    wr_fire       = 1'b0;
    wait_count_en = 1'b0;
    case (state)
      IDLE: if (start) state_next = CHECK;
      CHECK: begin
        if (msg_blocks == 8'd0 || 32'(msg_blocks) > MAX_BLOCKS) begin
          state_next = ERROR;
          err_next   = 3'd1;
        end else if (out_len_byte == 8'd0 || 32'(out_len_byte) > RATE_BYTES) begin
          state_next = ERROR;
          err_next   = 3'd2;
        end else begin
          state_next = INIT;
        end
      end
      INIT: begin
        k_start    = 1'b1;
        state_next = ABSORB;
      end
      ABSORB: begin
        if (!k_buffer_full) begin
          rd_issue = 1'b1;
          if (lane_cnt == LANE_W'(RATE_LANES - 1)) state_next = WAIT_PERM;
        end
      end
      WAIT_PERM: begin
        wait_count_en = 1'b1;
        k_last_block  = last_blk;
        if (k_ready) state_next = last_blk ? SQUEEZE : ABSORB;
      end
      SQUEEZE: begin
        if (k_dout_valid) begin
          wr_fire = 1'b1;
          if (rem_bytes <= 8'd8) state_next = DONE;
        end else begin
          wait_count_en = 1'b1;
        end
      end
      DONE: if (start) state_next = CHECK;
      ERROR: begin
        if (start) begin
          state_next = CHECK;
          err_next   = 3'd0;
        end
      end
      default: state_next = IDLE;
    endcase
    if (wait_count_en && wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
      state_next = ERROR;
      err_next   = 3'd3;
    end
    if (busy && abort) begin
      state_next = ERROR;
      err_next   = 3'd4;
      rd_issue   = 1'b0;
      wr_fire    = 1'b0;
    end
  end

  // RAM port drive: lane reads while absorbing, byte-masked lane writes while squeezing
  always_comb begin
    mem_en_a    = 1'b0;
    mem_we_a    = 1'b0;
    mem_addr_a  = '0;
    mem_wdata_a = '0;
    mem_be_a    = '0;
    mem_en_b    = 1'b0;
    mem_we_b    = 1'b0;
    mem_addr_b  = '0;
    mem_wdata_b = '0;
    mem_be_b    = '0;
    if (rd_issue) begin
      mem_en_a   = 1'b1;
      mem_en_b   = 1'b1;
      mem_addr_a = rd_addr;
      mem_addr_b = rd_addr + ADDR_WIDTH'(1);
      mem_be_a   = '1;
      mem_be_b   = '1;
    end else if (wr_fire) begin
      mem_en_a    = 1'b1;
      mem_en_b    = 1'b1;
      mem_we_a    = 1'b1;
      mem_we_b    = 1'b1;
      mem_addr_a  = wr_addr;
      mem_addr_b  = wr_addr + ADDR_WIDTH'(1);
      mem_wdata_a = k_dout[31:0];
      mem_wdata_b = k_dout[63:32];
      mem_be_a    = '1;
      mem_be_b    = '1;
      if (tail_lane) begin
        case (rem_bytes[2:0])
          3'd1: begin mem_be_a = 4'h1; mem_en_b = 1'b0; mem_we_b = 1'b0; mem_be_b = '0; end
          3'd2: begin mem_be_a = 4'h3; mem_en_b = 1'b0; mem_we_b = 1'b0; mem_be_b = '0; end
          3'd3: begin mem_be_a = 4'h7; mem_en_b = 1'b0; mem_we_b = 1'b0; mem_be_b = '0; end
          3'd4: begin mem_be_a = 4'hf; mem_en_b = 1'b0; mem_we_b = 1'b0; mem_be_b = '0; end
          3'd5: mem_be_b = 4'h1;
          3'd6: mem_be_b = 4'h3;
          3'd7: mem_be_b = 4'h7;
          default: mem_be_b = '1;
        endcase
      end
    end
  end

  // State, counters and job parameters; job inputs are captured during CHECK only
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      err_code    <= 3'd0;
      done        <= 1'b0;
      k_din_valid <= 1'b0;
      wait_cnt    <= '0;
      blocks_q    <= '0;
      blk_cnt     <= '0;
      lane_cnt    <= '0;
      rem_bytes   <= '0;
      rd_addr     <= '0;
      wr_addr     <= '0;
    end else begin
      state       <= state_next;
      err_code    <= err_next;
      done        <= (state_next == DONE) && (state != DONE);
      k_din_valid <= rd_issue;
      if (state_next != state) wait_cnt <= '0;
      else if (wait_count_en)  wait_cnt <= wait_cnt + WAIT_W'(1);
      if (state == CHECK) begin
        blocks_q  <= msg_blocks;
        rem_bytes <= out_len_byte;
        rd_addr   <= in_base_addr;
        wr_addr   <= out_base_addr;
      end
      if (state == INIT) begin
        lane_cnt <= '0;
        blk_cnt  <= '0;
      end
      if (rd_issue) begin
        rd_addr  <= rd_addr + ADDR_WIDTH'(2);
        lane_cnt <= (lane_cnt == LANE_W'(RATE_LANES - 1)) ? '0 : lane_cnt + LANE_W'(1);
      end
      if (state == WAIT_PERM && state_next == ABSORB) blk_cnt <= blk_cnt + 8'd1;
      if (wr_fire) begin
        wr_addr   <= wr_addr + ADDR_WIDTH'(2);
        rem_bytes <= rem_bytes - 8'd8;
      end
    end
  end

`ifdef ACCEL_PERF_CNT_EN
  // Busy-cycle counter: restarts in CHECK, saturates, and freezes once the job ends
  always_ff @(posedge clk) begin
    if (rst)                            perf_cycles <= '0;
    else if (state == CHECK)            perf_cycles <= '0;
    else if (busy && perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_accel_sponge_ctrl.sv
// tb_accel_sponge_ctrl: table-driven jobs against a RAM model and a simple core model,
// plus hand sequences for timeout, abort and mid-job reset.
module tb_accel_sponge_ctrl;

  typedef struct {
    logic [7:0]  blocks;
    logic [7:0]  len;
    logic [31:0] in_base;
    logic [31:0] out_base;
    logic [2:0]  exp_err;
    int          exp_reads;
    int          exp_lanes;
    logic        exp_en_b;
    logic [3:0]  exp_be_a;
    logic [3:0]  exp_be_b;
    bit          disturb;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [7:0]  msg_blocks, out_len_byte;
  logic [31:0] in_base_addr, out_base_addr;
  logic        busy, done;
  logic [2:0]  err_code;
  logic        mem_en_a, mem_we_a, mem_en_b, mem_we_b;
  logic [31:0] mem_addr_a, mem_wdata_a, mem_rdata_a, mem_addr_b, mem_wdata_b, mem_rdata_b;
  logic [3:0]  mem_be_a, mem_be_b;
  logic        k_start, k_din_valid, k_last_block;
  logic [63:0] k_din, k_dout;
  logic        k_buffer_full, k_ready, k_dout_valid;

  int tests_run = 0;
  int tests_failed = 0;
  int rd_cnt, din_cnt, wr_cnt, kstart_cnt, done_cnt, lastblk_cnt, lastblk_rd, lanes_rx;
  int perm_cnt = 0;
  bit core_stall = 1'b0;
  logic [31:0] tick = 32'd0;
  logic [31:0] cur_in, cur_out, exp_a;
  int          cur_lanes;
  logic        cur_en_b, fin, exp_en_b;
  logic [3:0]  cur_be_a, cur_be_b, exp_be_a, exp_be_b;
  vec_t        vecs[11];
  vec_t        vh;

  accel_sponge_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .msg_blocks(msg_blocks), .out_len_byte(out_len_byte),
    .in_base_addr(in_base_addr), .out_base_addr(out_base_addr),
    .busy(busy), .done(done), .err_code(err_code),
    .mem_en_a(mem_en_a), .mem_we_a(mem_we_a), .mem_addr_a(mem_addr_a),
    .mem_wdata_a(mem_wdata_a), .mem_be_a(mem_be_a), .mem_rdata_a(mem_rdata_a),
    .mem_en_b(mem_en_b), .mem_we_b(mem_we_b), .mem_addr_b(mem_addr_b),
    .mem_wdata_b(mem_wdata_b), .mem_be_b(mem_be_b), .mem_rdata_b(mem_rdata_b),
    .k_start(k_start), .k_din(k_din), .k_din_valid(k_din_valid), .k_last_block(k_last_block),
    .k_buffer_full(k_buffer_full), .k_ready(k_ready), .k_dout(k_dout), .k_dout_valid(k_dout_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // RAM model with one cycle of read latency
  always @(posedge clk) begin
    if (mem_en_a && !mem_we_a) mem_rdata_a <= ram_word(mem_addr_a);
    if (mem_en_b && !mem_we_b) mem_rdata_b <= ram_word(mem_addr_b);
  end

  // Core model: k_ready three cycles after a full block arrives, digest lanes every other cycle
  initial begin
    k_ready = 1'b0; k_dout_valid = 1'b0; k_dout = '0;
    forever begin
      @(posedge clk); #1;
      tick = tick + 32'd1;
      k_ready = 1'b0;
      if (core_stall) begin
        k_dout_valid = 1'b0;
        perm_cnt = 0;
      end else begin
        if (perm_cnt > 0) begin
          perm_cnt--;
          if (perm_cnt == 0) k_ready = 1'b1;
        end
        k_dout_valid = tick[0];
      end
      k_dout = {32'hC0DE_0000 ^ tick, tick ^ 32'h0F0F_1234};
    end
  end

  // Bus monitor: checks every read, delivered lane and write against the expected job
  initial begin
    forever begin
      @(negedge clk);
      if (mem_en_a && !mem_we_a) begin
        exp_a = cur_in + 32'(2 * rd_cnt);
        checkOutput("rd_port", {mem_addr_a, mem_addr_b, mem_en_b, mem_we_b, mem_be_a, mem_be_b},
                    {exp_a, exp_a + 32'd1, 1'b1, 1'b0, 4'hf, 4'hf});
        rd_cnt++;
      end
      if (k_din_valid) begin
        exp_a = cur_in + 32'(2 * din_cnt);
        checkOutput("k_din", k_din, {ram_word(exp_a + 32'd1), ram_word(exp_a)});
        din_cnt++;
        lanes_rx++;
        if (lanes_rx == 21) begin
          lanes_rx = 0;
          perm_cnt = 3;
        end
      end
      if (mem_en_a && mem_we_a) begin
        exp_a    = cur_out + 32'(2 * wr_cnt);
        fin      = (wr_cnt == cur_lanes - 1);
        exp_en_b = fin ? cur_en_b : 1'b1;
        exp_be_a = fin ? cur_be_a : 4'hf;
        exp_be_b = fin ? cur_be_b : 4'hf;
        checkOutput("wr_a", {mem_addr_a, mem_wdata_a, mem_be_a}, {exp_a, k_dout[31:0], exp_be_a});
        checkOutput("wr_en_b", mem_en_b, exp_en_b);
        if (exp_en_b)
          checkOutput("wr_b", {mem_addr_b, mem_wdata_b, mem_we_b, mem_be_b},
                      {exp_a + 32'd1, k_dout[63:32], 1'b1, exp_be_b});
        wr_cnt++;
      end
      if (k_start) kstart_cnt++;
      if (done) done_cnt++;
      if (k_last_block) begin
        if (lastblk_cnt == 0) lastblk_rd = rd_cnt;
        lastblk_cnt++;
      end
    end
  end

  task automatic startJob(input vec_t v);
    @(posedge clk); #1;
    cur_in = v.in_base; cur_out = v.out_base; cur_lanes = v.exp_lanes;
    cur_en_b = v.exp_en_b; cur_be_a = v.exp_be_a; cur_be_b = v.exp_be_b;
    rd_cnt = 0; din_cnt = 0; wr_cnt = 0; kstart_cnt = 0; done_cnt = 0;
    lastblk_cnt = 0; lastblk_rd = -1; lanes_rx = 0;
    msg_blocks = v.blocks; out_len_byte = v.len;
    in_base_addr = v.in_base; out_base_addr = v.out_base;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (v.disturb) begin
      repeat (3) @(posedge clk);
      #1;
      msg_blocks = 8'd0; out_len_byte = 8'd200; in_base_addr = 32'h999; out_base_addr = 32'h777;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int cyc;
    startJob(v);
    cyc = 0;
    while (cyc < 3000 && !(done_cnt > 0 || (err_code != 3'd0 && !busy))) begin
      @(negedge clk); #1;
      cyc++;
    end
    checkOutput("job_finished", (cyc < 3000), 1'b1);
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic runVector(input vec_t v);
    bit ok;
    ok = (v.exp_err == 3'd0);
    applyStimulus(v);
    checkOutput("err_code", err_code, v.exp_err);
    checkOutput("busy_end", busy, 1'b0);
    checkOutput("reads", rd_cnt, v.exp_reads);
    checkOutput("din_lanes", din_cnt, v.exp_reads);
    checkOutput("writes", wr_cnt, v.exp_lanes);
    checkOutput("k_start_pulses", kstart_cnt, ok ? 1 : 0);
    checkOutput("done_pulses", done_cnt, ok ? 1 : 0);
    checkOutput("last_block_cycles", lastblk_cnt, ok ? 4 : 0);
    if (ok) checkOutput("last_block_after_reads", lastblk_rd, v.exp_reads);
  endtask

  // Global time bound so the run can never hang
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt;
    vecs[0]  = '{8'd1,  8'd32,  32'h0,         32'h40,   3'd0, 21,  4,  1'b1, 4'hf, 4'hf, 1'b0};
    vecs[1]  = '{8'd3,  8'd32,  32'h0,         32'h100,  3'd0, 63,  4,  1'b1, 4'hf, 4'hf, 1'b0};
    vecs[2]  = '{8'd1,  8'd13,  32'h200,       32'h300,  3'd0, 21,  2,  1'b1, 4'hf, 4'h1, 1'b1};
    vecs[3]  = '{8'd1,  8'd3,   32'h400,       32'h500,  3'd0, 21,  1,  1'b0, 4'h7, 4'h0, 1'b0};
    vecs[4]  = '{8'd0,  8'd32,  32'h0,         32'h40,   3'd1, 0,   0,  1'b1, 4'hf, 4'hf, 1'b0};
    vecs[5]  = '{8'd1,  8'd169, 32'h0,         32'h40,   3'd2, 0,   0,  1'b1, 4'hf, 4'hf, 1'b0};
    vecs[6]  = '{8'd17, 8'd8,   32'h0,         32'h40,   3'd1, 0,   0,  1'b1, 4'hf, 4'hf, 1'b0};
    vecs[7]  = '{8'd1,  8'd0,   32'h0,         32'h40,   3'd2, 0,   0,  1'b1, 4'hf, 4'hf, 1'b0};
    vecs[8]  = '{8'd2,  8'd168, 32'hFFFF_FFF0, 32'h20,   3'd0, 42,  21, 1'b1, 4'hf, 4'hf, 1'b0};
    vecs[9]  = '{8'd16, 8'd4,   32'h1000,      32'h2000, 3'd0, 336, 1,  1'b0, 4'hf, 4'h0, 1'b0};
    vecs[10] = '{8'd1,  8'd7,   32'h600,       32'h700,  3'd0, 21,  1,  1'b1, 4'hf, 4'h7, 1'b0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; k_buffer_full = 1'b0;
    msg_blocks = '0; out_len_byte = '0; in_base_addr = '0; out_base_addr = '0;
    rd_cnt = 0; din_cnt = 0; wr_cnt = 0; kstart_cnt = 0; done_cnt = 0;
    lastblk_cnt = 0; lastblk_rd = -1; lanes_rx = 0;
    cur_in = '0; cur_out = '0; cur_lanes = 0; cur_en_b = 1'b1; cur_be_a = 4'hf; cur_be_b = 4'hf;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checkOutput("reset_outputs",
                {busy, done, err_code, mem_en_a, mem_en_b, mem_we_a, mem_we_b, k_start,
                 k_din_valid, k_last_block, k_din}, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 11; i++) runVector(vecs[i]);

    // k_ready never arrives: exactly TIMEOUT cycles in WAIT_PERM, then error 3
    vh = '{8'd1, 8'd8, 32'h800, 32'h900, 3'd3, 21, 1, 1'b1, 4'hf, 4'hf, 1'b0};
    core_stall = 1'b1;
    startJob(vh);
    cnt = 0;
    while (lastblk_cnt == 0 && cnt < 200) begin
      @(negedge clk); #1;
      cnt++;
    end
    checkOutput("timeout_reached_wait", (cnt < 200), 1'b1);
    cnt = 0;
    while (err_code == 3'd0 && cnt < 1100) begin
      @(negedge clk); #1;
      cnt++;
    end
    checkOutput("timeout_cycles", cnt, 1024);
    checkOutput("timeout_err", err_code, 3'd3);
    checkOutput("timeout_busy", busy, 1'b0);
    checkOutput("timeout_last_block_cycles", lastblk_cnt, 1024);
    checkOutput("timeout_reads", din_cnt, 21);
    core_stall = 1'b0;
    runVector(vecs[0]);

    // Abort mid-ABSORB: enables drop at once, error 4 the following cycle
    vh = '{8'd2, 8'd16, 32'h80, 32'hA00, 3'd4, 0, 0, 1'b1, 4'hf, 4'hf, 1'b0};
    startJob(vh);
    cnt = 0;
    while (rd_cnt < 5 && cnt < 100) begin
      @(negedge clk); #1;
      cnt++;
    end
    @(posedge clk); #1;
    abort = 1'b1;
    @(negedge clk); #1;
    checkOutput("abort_en_drop", {mem_en_a, mem_en_b}, 2'b00);
    checkOutput("abort_busy_same_cycle", busy, 1'b1);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk); #1;
    checkOutput("abort_busy_next", busy, 1'b0);
    checkOutput("abort_err", err_code, 3'd4);
    checkOutput("abort_no_lane", k_din_valid, 1'b0);
    checkOutput("abort_no_writes", wr_cnt, 0);

    // Reset during SQUEEZE returns to IDLE with quiet outputs; a new job then completes
    startJob(vecs[0]);
    cnt = 0;
    while (wr_cnt < 1 && cnt < 300) begin
      @(negedge clk); #1;
      cnt++;
    end
    checkOutput("squeeze_reached", (cnt < 300), 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    checkOutput("rst_squeeze_outputs",
                {busy, done, err_code, mem_en_a, mem_en_b, mem_we_a, mem_we_b, k_start,
                 k_din_valid, k_last_block, k_din, mem_addr_a, mem_be_a}, '0);
    checkOutput("rst_no_done", done_cnt, 0);
    runVector(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
